// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU with a valid/busy handshake.
// Single-cycle logic/arith/compare ops and an iterative shift-add multiplier.
// Define ALU_SEQ_DIV_EN to build the iterative restoring unsigned divider
// (DIVU/REMU); without it those codes behave as unknown ops.
module alu_seq #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              ovf_o
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] OP_MUL  = CTRL_W'(4'b0011);
    localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(4'b1000);
    localparam logic [CTRL_W-1:0] OP_NOR  = CTRL_W'(4'b1100);
    localparam logic [CTRL_W-1:0] OP_NAND = CTRL_W'(4'b1101);
`ifdef ALU_SEQ_DIV_EN
    localparam logic [CTRL_W-1:0] OP_DIVU = CTRL_W'(4'b0100);
    localparam logic [CTRL_W-1:0] OP_REMU = CTRL_W'(4'b0101);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef ALU_SEQ_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] acc_nxt;
`ifdef ALU_SEQ_DIV_EN
    logic [DATA_W-1:0] dvsr_q, dvsr_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              is_rem_q, is_rem_d;
    logic [DATA_W:0]   rem_sh, rem_diff;
    logic [DATA_W-1:0] rem_nxt, quo_nxt;
`endif

    logic [DATA_W-1:0] sc_res, add_r, sub_r;
    logic              sc_ovf, accept;

    // Single-cycle datapath, evaluated straight from the ports on the accepting edge
    always_comb begin
        add_r  = src1_i + src2_i;
        sub_r  = src1_i - src2_i;
        sc_res = '0;
        sc_ovf = 1'b0;
        case (ctrl_i)
            OP_AND:  sc_res = src1_i & src2_i;
            OP_OR:   sc_res = src1_i | src2_i;
            OP_ADD: begin
                sc_res = add_r;
                sc_ovf = (src1_i[DATA_W-1] == src2_i[DATA_W-1]) &&
                         (add_r[DATA_W-1] != src1_i[DATA_W-1]);
            end
            OP_SUB: begin
                sc_res = sub_r;
                sc_ovf = (src1_i[DATA_W-1] != src2_i[DATA_W-1]) &&
                         (sub_r[DATA_W-1] != src1_i[DATA_W-1]);
            end
            OP_NOR:  sc_res = ~(src1_i | src2_i);
            OP_NAND: sc_res = ~(src1_i & src2_i);
            OP_SLT:  sc_res = {{(DATA_W-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
            OP_SLTU: sc_res = {{(DATA_W-1){1'b0}}, src1_i < src2_i};
            default: sc_res = '0;
        endcase
    end

    // FSM next state, iteration step and result/flag update
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef ALU_SEQ_DIV_EN
        dvsr_d   = dvsr_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        is_rem_d = is_rem_q;
        // Restoring step: shift next dividend bit into the partial remainder
        rem_sh   = {rem_q, quo_q[DATA_W-1]};
        rem_diff = rem_sh - {1'b0, dvsr_q};
        rem_nxt  = rem_diff[DATA_W] ? rem_sh[DATA_W-1:0] : rem_diff[DATA_W-1:0];
        quo_nxt  = {quo_q[DATA_W-2:0], ~rem_diff[DATA_W]};
`endif
        // DONE accepts a new request just like IDLE, giving bubble-free issue
        accept   = start_i && (state_q == S_IDLE || state_q == S_DONE);

        case (state_q)
            S_MUL: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    res_d   = acc_nxt;
                    zero_d  = (acc_nxt == '0);
                    ovf_d   = 1'b0;
                end
            end
`ifdef ALU_SEQ_DIV_EN
            S_DIV: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    res_d   = is_rem_q ? rem_nxt : quo_nxt;
                    zero_d  = ((is_rem_q ? rem_nxt : quo_nxt) == '0);
                    ovf_d   = 1'b0;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (ctrl_i == OP_MUL) begin
                        state_d  = S_MUL;
                        mcand_d  = src1_i;
                        mplier_d = src2_i;
                        acc_d    = '0;
                        cnt_d    = CNT_MAX;
`ifdef ALU_SEQ_DIV_EN
                    end else if (ctrl_i == OP_DIVU || ctrl_i == OP_REMU) begin
                        state_d  = S_DIV;
                        dvsr_d   = src2_i;
                        quo_d    = src1_i;
                        rem_d    = '0;
                        is_rem_d = (ctrl_i == OP_REMU);
                        cnt_d    = CNT_MAX;
`endif
                    end else begin
                        state_d = S_DONE;
                        res_d   = sc_res;
                        zero_d  = (sc_res == '0);
                        ovf_d   = sc_ovf;
                    end
                end
            end
        endcase
    end

    // State and working registers; reset aborts any operation in flight
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            res_q    <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
`ifdef ALU_SEQ_DIV_EN
            dvsr_q   <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            is_rem_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
`ifdef ALU_SEQ_DIV_EN
            dvsr_q   <= dvsr_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            is_rem_q <= is_rem_d;
`endif
        end
    end

    assign busy_o   = (state_q == S_MUL)
`ifdef ALU_SEQ_DIV_EN
                    || (state_q == S_DIV)
`endif
                    ;
    assign done_o   = (state_q == S_DONE);
    assign result_o = res_q;
    assign zero_o   = zero_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 32-bit and an 8-bit instance share clock/reset.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st32, st8;
    logic [31:0] a32, b32, res32;
    logic [7:0]  a8, b8, res8;
    logic [3:0]  c32, c8;
    logic        busy32, done32, zero32, ovf32;
    logic        busy8, done8, zero8, ovf8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.DATA_W(32), .CTRL_W(4)) d32 (
        .clk_i(clk), .rst_i(rst_n), .start_i(st32), .src1_i(a32), .src2_i(b32),
        .ctrl_i(c32), .busy_o(busy32), .done_o(done32), .result_o(res32),
        .zero_o(zero32), .ovf_o(ovf32)
    );

    alu_seq #(.DATA_W(8), .CTRL_W(4)) d8 (
        .clk_i(clk), .rst_i(rst_n), .start_i(st8), .src1_i(a8), .src2_i(b8),
        .ctrl_i(c8), .busy_o(busy8), .done_o(done8), .result_o(res8),
        .zero_o(zero8), .ovf_o(ovf8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op; returns in the done cycle (or after a bounded wait).
    // Inputs are scrambled after acceptance; with poke, a start pulse lands while busy.
    task automatic issue(input bit w8, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input bit poke,
                         output int lat, output int bcnt);
        @(negedge clk);
        if (w8) begin st8 = 1'b1; c8 = c; a8 = a[7:0]; b8 = b[7:0]; end
        else    begin st32 = 1'b1; c32 = c; a32 = a; b32 = b; end
        @(posedge clk); #1;
        st32 = 1'b0; st8 = 1'b0;
        a32 = $urandom; b32 = $urandom; c32 = 4'b0010;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 4'b0010;
        lat = 1; bcnt = 0;
        while (!(w8 ? done8 : done32) && lat < 100) begin
            if (w8 ? busy8 : busy32) bcnt++;
            if (poke && lat == 3) begin st32 = !w8; st8 = w8; end
            if (poke && lat == 4) begin st32 = 1'b0; st8 = 1'b0; end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, ndone;
        rst_n = 1'b0;
        st32 = 0; st8 = 0; a32 = 0; b32 = 0; c32 = 0; a8 = 0; b8 = 0; c8 = 0;
        #12;
        check("rst_busy", busy32, 0);
        check("rst_done", done32, 0);
        check("rst_res", res32, 0);
        check("rst_zero", zero32, 1);
        check("rst_ovf", ovf32, 0);
        @(negedge clk); rst_n = 1'b1;

        // ADD overflow
        issue(0, 4'b0010, 32'h7FFF_FFFF, 32'h1, 0, lat, bcnt);
        check("add_lat", lat, 1);
        check("add_res", res32, 32'h8000_0000);
        check("add_ovf", ovf32, 1);
        check("add_zero", zero32, 0);
        check("add_busy", bcnt, 0);

        // Reset mid-MUL, in cycle 5 after accept
        @(negedge clk); st32 = 1'b1; c32 = 4'b0011; a32 = 32'h3; b32 = 32'h5;
        @(posedge clk); #1; st32 = 1'b0;
        repeat (4) @(posedge clk);
        #2; check("pre_rst_busy", busy32, 1);
        rst_n = 1'b0; #1;
        check("arst_busy", busy32, 0);
        check("arst_done", done32, 0);
        check("arst_res", res32, 0);
        check("arst_zero", zero32, 1);
        check("arst_ovf", ovf32, 0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done32) ndone++;
        end
        check("arst_no_done", ndone, 0);

        issue(0, 4'b0110, 32'd5, 32'd5, 0, lat, bcnt);
        check("sub_res", res32, 0);
        check("sub_zero", zero32, 1);
        check("sub_ovf", ovf32, 0);
        issue(0, 4'b0110, 32'h8000_0000, 32'h1, 0, lat, bcnt);
        check("subovf_res", res32, 32'h7FFF_FFFF);
        check("subovf_ovf", ovf32, 1);
        issue(0, 4'b0111, 32'hFFFF_FFFF, 32'h1, 0, lat, bcnt);
        check("slt_res", res32, 1);
        issue(0, 4'b1000, 32'hFFFF_FFFF, 32'h1, 0, lat, bcnt);
        check("sltu_res", res32, 0);
        issue(0, 4'b1100, 32'h0, 32'h0, 0, lat, bcnt);
        check("nor_res", res32, 32'hFFFF_FFFF);
        issue(0, 4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bcnt);
        check("nand_res", res32, 0);
        issue(0, 4'b0000, 32'hF0F0_1234, 32'hFF00_00FF, 0, lat, bcnt);
        check("and_res", res32, 32'hF000_0034);
        issue(0, 4'b0001, 32'hF0F0_1234, 32'h0F00_00FF, 0, lat, bcnt);
        check("or_res", res32, 32'hFFF0_12FF);
        issue(0, 4'b1111, 32'h1234, 32'h5678, 0, lat, bcnt);
        check("unk_res", res32, 0);
        check("unk_lat", lat, 1);

        // MUL with ignored start pulses during busy
        issue(0, 4'b0011, 32'h0001_0003, 32'h0002_0005, 1, lat, bcnt);
        check("mul_res", res32, 32'h000B_000F);
        check("mul_lat", lat, 33);
        check("mul_busy", bcnt, 32);
        check("mul_done_busy", busy32, 0);
        check("mul_ovf", ovf32, 0);
        @(posedge clk); #1;
        check("mul_done_pulse", done32, 0);

`ifdef ALU_SEQ_DIV_EN
        issue(0, 4'b0100, 32'd100, 32'd7, 0, lat, bcnt);
        check("divu_res", res32, 14);
        check("divu_lat", lat, 33);
        issue(0, 4'b0101, 32'd100, 32'd7, 0, lat, bcnt);
        check("remu_res", res32, 2);
        check("remu_lat", lat, 33);
        issue(0, 4'b0100, 32'd9, 32'd0, 0, lat, bcnt);
        check("divz_res", res32, 32'hFFFF_FFFF);
        check("divz_lat", lat, 33);
        check("divz_ovf", ovf32, 0);
        issue(0, 4'b0101, 32'd9, 32'd0, 0, lat, bcnt);
        check("remz_res", res32, 9);
        check("remz_lat", lat, 33);
`else
        issue(0, 4'b0100, 32'd100, 32'd7, 0, lat, bcnt);
        check("divu_off_res", res32, 0);
        check("divu_off_zero", zero32, 1);
        check("divu_off_lat", lat, 1);
`endif

        // Back-to-back: ADD issued in the DONE cycle of a MUL
        issue(0, 4'b0011, 32'd6, 32'd7, 0, lat, bcnt);
        check("b2b_mul_res", res32, 42);
        st32 = 1'b1; c32 = 4'b0010; a32 = 32'd2; b32 = 32'd3;
        @(posedge clk); #1; st32 = 1'b0;
        check("b2b_done", done32, 1);
        check("b2b_res", res32, 5);
        @(posedge clk); #1;
        check("b2b_done_end", done32, 0);

        // 8-bit instance
        issue(1, 4'b0010, 32'h7F, 32'h1, 0, lat, bcnt);
        check("w8_add_res", {24'h0, res8}, 32'h80);
        check("w8_add_ovf", ovf8, 1);
        issue(1, 4'b0110, 32'h5, 32'h5, 0, lat, bcnt);
        check("w8_sub_zero", zero8, 1);
        issue(1, 4'b0111, 32'hFF, 32'h1, 0, lat, bcnt);
        check("w8_slt_res", {24'h0, res8}, 1);
        issue(1, 4'b0011, 32'h13, 32'h11, 1, lat, bcnt);
        check("w8_mul_res", {24'h0, res8}, 32'h43);
        check("w8_mul_lat", lat, 9);
        check("w8_mul_busy", bcnt, 8);
`ifdef ALU_SEQ_DIV_EN
        issue(1, 4'b0100, 32'd100, 32'd7, 0, lat, bcnt);
        check("w8_divu_res", {24'h0, res8}, 14);
        check("w8_divu_lat", lat, 9);
        issue(1, 4'b0100, 32'd9, 32'd0, 0, lat, bcnt);
        check("w8_divz_res", {24'h0, res8}, 32'hFF);
`else
        issue(1, 4'b0100, 32'd100, 32'd7, 0, lat, bcnt);
        check("w8_divu_off_res", {24'h0, res8}, 0);
        check("w8_divu_off_lat", lat, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered, multi-cycle ALU for the multi-cycle CPU datapath.
- Generalises the single-cycle ALU in three ways: configurable data width, signed/unsigned compare, and an iterative shift-add multiplier.
- Optional iterative unsigned divider.
- Uses a valid/busy handshake so the control FSM can stall on long operations.

Parameters:
- DATA_W, 32, operand/result width in bits (min 4).
- CTRL_W, 4, width of operation select.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-low.
- start_i  input  1  operation request; sampled only when busy_o=0.
- src1_i  input  DATA_W  operand A.
- src2_i  input  DATA_W  operand B.
- ctrl_i  input  CTRL_W  operation select.
- busy_o  output  1  high while an operation is executing.
- done_o  output  1  one-cycle pulse when result_o/flags are updated.
- result_o  output  DATA_W  registered result, held until next done_o.
- zero_o  output  1  registered, result_o == 0.
- ovf_o  output  1  registered signed overflow for ADD/SUB, else 0.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE; busy_o=0, done_o=0, result_o=0, zero_o=1, ovf_o=0; multiplier/divider working registers cleared.
- Op codes:
  - AND 0000: A&B.
  - OR 0001: A|B.
  - ADD 0010: A+B, modulo 2^DATA_W.
  - SUB 0110: A-B, modulo 2^DATA_W.
  - NOR 1100: ~(A|B).
  - NAND 1101: ~(A&B).
  - SLT 0111: signed A<B ? 1 : 0.
  - SLTU 1000: unsigned A<B ? 1 : 0.
  - MUL 0011: low DATA_W bits of A*B.
  - DIVU 0100: unsigned quotient A/B.
  - REMU 0101: unsigned remainder A%B.
  - Any other code: result 0, single-cycle.
- Operands and ctrl_i are latched on the accepting edge; later input changes do not affect an in-flight operation.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE + start_i, single-cycle op:
    - result computed and registered on the accepting edge;
    - done_o=1 in the following cycle;
    - busy_o stays 0;
    - latency 1.
  - IDLE + start_i, MUL:
    - -> MUL; busy_o=1 from the next cycle;
    - one multiplier bit per cycle, LSB first, DATA_W iterations;
    - -> DONE; done_o pulses with busy_o=0.
    - Total latency DATA_W+1 cycles from accept to done_o.
  - IDLE + start_i, DIVU/REMU: -> DIV, restoring division, one quotient bit per cycle, DATA_W iterations, then -> DONE. Latency DATA_W+1.
  - DONE: done_o=1 for exactly one cycle; returns to IDLE.
    - start_i in DONE is accepted (back-to-back issue, no bubble).
- start_i while busy_o=1 is ignored; no queueing.
- ovf_o:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from A.
  - 0 for every other op.
- Divide by zero:
  - DIVU returns all ones; REMU returns A.
  - Still takes the full DATA_W+1 cycles (no early exit).
  - ovf_o=0.
- MUL overflow beyond DATA_W bits is discarded silently.
- Reset asserted mid-operation aborts immediately to IDLE with reset values. No done_o is produced for the aborted op.
- zero_o, ovf_o, result_o change only on done_o cycles (and on reset).

Optional Feature:
- ALU_SEQ_DIV_EN defined: DIVU/REMU implemented as above.
- Not defined:
  - DIV state and divider registers are not synthesised.
  - DIVU/REMU treated as unknown codes: result 0, zero_o=1, single-cycle latency.

Test Plan:
- Reset: drive rst_i=0 mid-MUL (cycle 5) -> busy_o=0, done_o=0, result_o=0, zero_o=1 immediately, before the next clock edge. No done_o after release.
- ADD overflow and flags (DATA_W=32):
  - ADD 0x7FFFFFFF+1 -> result 0x80000000, ovf_o=1, zero_o=0, done_o one cycle after start.
  - SUB 5-5 -> 0, zero_o=1, ovf_o=0.
- Compares: SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0; NOR 0,0 -> 0xFFFFFFFF; NAND all-ones, all-ones -> 0.
- MUL: 0x0001_0003 * 0x0002_0005 -> 0x000B_000F.
  - busy_o high for 32 cycles; done_o exactly 33 cycles after accept.
  - start_i pulses during busy are ignored.
- DIV (ALU_SEQ_DIV_EN):
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
  - Each takes 33 cycles.
  - Without the macro: DIVU 100/7 -> 0 after 1 cycle.
- Back-to-back and parametrisation:
  - start_i asserted in the DONE cycle of a MUL with ADD 2+3 -> next done_o one cycle later with result 5.
  - Rerun all scenarios with DATA_W=8; e.g. MUL 0x13*0x11 -> 0x43.
